// File: rtl/present80_seq_if.sv
// Register-file / datapath / status bundle around the PRESENT-80 sequencer.
// slave = sequencer view; master = register file plus round datapath view.
interface present80_seq_if #(
    parameter int KEY_W = 80
);
    logic [KEY_W-1:0] cfg_key;
    logic [63:0]      cfg_plain;
    logic             ctrl_start;
    logic             ctrl_abort;
    logic             ctrl_irq_en;
    logic             done_clr;
    logic             core_load;
    logic             core_round_en;
    logic [4:0]       core_round;
    logic             core_final;
    logic [63:0]      core_state;
    logic [63:0]      cipher_out;
    logic             busy;
    logic             done;
    logic             overrun;
    logic             irq;

    modport master (
        output cfg_key, cfg_plain, ctrl_start, ctrl_abort, ctrl_irq_en, done_clr, core_state,
        input  core_load, core_round_en, core_round, core_final,
        input  cipher_out, busy, done, overrun, irq
    );

    modport slave (
        input  ctrl_start, ctrl_abort, ctrl_irq_en, done_clr, core_state,
        output core_load, core_round_en, core_round, core_final,
        output cipher_out, busy, done, overrun, irq
    );
endinterface

// File: rtl/present80_seq.sv
// PRESENT-80 sequencer: start edge -> load, ROUNDS rounds, final XOR, capture; done 35 cycles after start.
// No backpressure: start edges while busy are dropped and flagged as overrun; abort returns to idle.
module present80_seq #(
    parameter int ROUNDS = 31,
    parameter int KEY_W  = 80
) (
    input  logic            clk,
    input  logic            reset,
    present80_seq_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_CAPTURE
    } state_t;

    localparam logic [4:0] LastRound = 5'(ROUNDS);

    // The datapath key schedule only exists for the 80-bit key variant.
    if (KEY_W != 80) begin : g_key_w_unsupported
    end

    state_t      r_state;
    state_t      w_next;
    logic [4:0]  r_cnt;
    logic [4:0]  w_cnt_nxt;
    logic        r_start_q;
    logic        r_done;
    logic        r_overrun;
    logic [63:0] r_cipher;
    logic        w_start_edge;
    logic        w_busy;
    logic        w_abortable;

    assign w_start_edge = bus.ctrl_start & ~r_start_q;
    assign w_busy       = (r_state != S_IDLE);
    assign w_abortable  = (r_state == S_LOAD) || (r_state == S_ROUND) || (r_state == S_FINAL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 5'd0;
            r_start_q <= 1'b0;
            r_cipher  <= 64'h0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_nxt;
            r_start_q <= bus.ctrl_start;
            if (r_state == S_CAPTURE) begin
                r_cipher <= bus.core_state;
            end
            // Completion beats a coincident clear so software never loses a result.
            if (r_state == S_CAPTURE) begin
                r_done <= 1'b1;
            end else if (bus.done_clr || ((r_state == S_IDLE) && w_start_edge)) begin
                r_done <= 1'b0;
            end
            if (w_busy && w_start_edge) begin
                r_overrun <= 1'b1;
            end else if (bus.done_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next            = r_state;
        w_cnt_nxt         = r_cnt;
        bus.core_load     = 1'b0;
        bus.core_round_en = 1'b0;
        bus.core_round    = 5'd0;
        bus.core_final    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_edge) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                bus.core_load = 1'b1;
                w_cnt_nxt     = 5'd1;
                w_next        = S_ROUND;
            end
            S_ROUND: begin
                bus.core_round_en = 1'b1;
                bus.core_round    = r_cnt;
                if (r_cnt == LastRound) begin
                    w_next = S_FINAL;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            S_FINAL: begin
                bus.core_final = 1'b1;
                w_next         = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (bus.ctrl_abort && w_abortable) begin
            w_next = S_IDLE;
        end
    end

    assign bus.cipher_out = r_cipher;
    assign bus.busy       = w_busy;
    assign bus.done       = r_done;
    assign bus.overrun    = r_overrun;
    assign bus.irq        = r_done & bus.ctrl_irq_en;
endmodule

// File: tb/tb_present80_seq.sv
// Directed bench for present80_seq with a behavioural PRESENT-80 round datapath.
module tb_present80_seq;
    localparam logic [63:0] CT_ZERO = 64'h5579C1387B228445;
    localparam logic [63:0] CT_ONES = 64'h3333DCD3213210D2;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    present80_seq_if #(.KEY_W(80)) sif ();

    present80_seq #(.ROUNDS(31), .KEY_W(80)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sif.slave)
    );

    function automatic logic [3:0] sb(input logic [3:0] x);
        case (x)
            4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
            4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
            4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
            4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] round_fn(input logic [63:0] s, input logic [63:0] rk);
        logic [63:0] t;
        logic [63:0] p;
        t = s ^ rk;
        for (int n = 0; n < 16; n++) t[n*4 +: 4] = sb(t[n*4 +: 4]);
        p = '0;
        for (int i = 0; i < 63; i++) p[(i * 16) % 63] = t[i];
        p[63] = t[63];
        return p;
    endfunction

    function automatic logic [79:0] key_upd(input logic [79:0] k, input logic [4:0] rc);
        logic [79:0] r;
        r          = {k[18:0], k[79:19]};
        r[79:76]   = sb(r[79:76]);
        r[19:15]   = r[19:15] ^ rc;
        return r;
    endfunction

    // Round datapath: never reset, reloaded on every core_load.
    logic [63:0] dp_state = 64'h0;
    logic [79:0] dp_key   = 80'h0;
    always @(posedge clk) begin
        if (sif.core_load) begin
            dp_state <= sif.cfg_plain;
            dp_key   <= sif.cfg_key;
        end else if (sif.core_round_en) begin
            dp_state <= round_fn(dp_state, dp_key[79:16]);
            dp_key   <= key_upd(dp_key, sif.core_round);
        end else if (sif.core_final) begin
            dp_state <= dp_state ^ dp_key[79:16];
        end
    end
    assign sif.core_state = dp_state;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ctl_vec();
        return 64'({sif.core_load, sif.core_round_en, sif.core_round, sif.core_final,
                    sif.busy, sif.done, sif.overrun, sif.irq});
    endfunction

    // One full operation from a start edge driven now; ends in cycle 35.
    task automatic run_op(input string tag, input logic [79:0] key, input logic [63:0] pt,
                          input logic [63:0] exp_ct, input int ovr_cycle, input bit clr34);
        logic [63:0] e;
        sif.cfg_key    = key;
        sif.cfg_plain  = pt;
        sif.ctrl_start = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            tick();
            e = 64'({(c == 1), (c >= 2 && c <= 32), ((c >= 2 && c <= 32) ? 5'(c - 1) : 5'd0),
                     (c == 33), 1'b1, 1'b0, (ovr_cycle != 0 && c > ovr_cycle), 1'b0});
            chk($sformatf("%s_c%0d", tag, c), ctl_vec(), e);
            if (c == 1) sif.ctrl_start = 1'b0;
            if (ovr_cycle != 0 && c == ovr_cycle) sif.ctrl_start = 1'b1;
            if (ovr_cycle != 0 && c == ovr_cycle + 1) sif.ctrl_start = 1'b0;
            if (clr34 && c == 34) sif.done_clr = 1'b1;
        end
        tick();
        sif.done_clr = 1'b0;
        chk({tag, "_done"}, 64'({sif.busy, sif.done}), 64'h1);
        chk({tag, "_irq"}, 64'(sif.irq), 64'(sif.ctrl_irq_en));
        chk({tag, "_ct"}, sif.cipher_out, exp_ct);
    endtask

    initial begin
        int loads;
        int finals;
        int n;
        reset           = 1'b0;
        sif.cfg_key     = '0;
        sif.cfg_plain   = '0;
        sif.ctrl_start  = 1'b0;
        sif.ctrl_abort  = 1'b0;
        sif.ctrl_irq_en = 1'b0;
        sif.done_clr    = 1'b0;
        tick();
        tick();
        chk("rst_ctl", ctl_vec(), 64'h0);
        chk("rst_ct", sif.cipher_out, 64'h0);
        reset = 1'b1;
        tick();

        run_op("zero", 80'h0, 64'h0, CT_ZERO, 0, 1'b0);
        tick();

        sif.ctrl_irq_en = 1'b1;
        run_op("ones", {80{1'b1}}, {64{1'b1}}, CT_ONES, 0, 1'b0);
        sif.done_clr = 1'b1;
        tick();
        sif.done_clr = 1'b0;
        chk("ones_clr", 64'({sif.done, sif.irq}), 64'h0);
        sif.ctrl_irq_en = 1'b0;
        tick();

        // Start held high for 100 cycles must launch exactly one operation.
        sif.cfg_key    = '0;
        sif.cfg_plain  = '0;
        sif.ctrl_start = 1'b1;
        loads = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (sif.core_load) loads++;
        end
        chk("held_loads", 64'(loads), 64'd1);
        chk("held_done", 64'({sif.busy, sif.done, sif.overrun}), 64'h2);
        chk("held_ct", sif.cipher_out, CT_ZERO);
        sif.ctrl_start = 1'b0;
        tick();

        run_op("ovr", {80{1'b1}}, {64{1'b1}}, CT_ONES, 10, 1'b0);
        chk("ovr_flag", 64'(sif.overrun), 64'h1);
        sif.done_clr = 1'b1;
        tick();
        sif.done_clr = 1'b0;
        chk("ovr_clr", 64'({sif.done, sif.overrun}), 64'h0);
        tick();

        // Abort in cycle 15 (round 14).
        sif.cfg_key    = '0;
        sif.cfg_plain  = '0;
        sif.ctrl_start = 1'b1;
        finals = 0;
        loads  = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (sif.core_final) finals++;
            if (sif.core_load) loads++;
            if (c == 1) sif.ctrl_start = 1'b0;
            if (c == 15) begin
                chk("abort_round14", 64'({sif.core_round_en, sif.core_round}), 64'h2E);
                sif.ctrl_abort = 1'b1;
            end
            if (c == 16) begin
                sif.ctrl_abort = 1'b0;
                chk("abort_c16", ctl_vec(), 64'h0);
                chk("abort_ct", sif.cipher_out, CT_ONES);
            end
        end
        chk("abort_finals", 64'(finals), 64'd0);
        chk("abort_loads", 64'(loads), 64'd1);
        chk("abort_done", 64'({sif.busy, sif.done}), 64'h0);

        // Asynchronous reset in cycle 20 of an operation.
        sif.ctrl_start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) sif.ctrl_start = 1'b0;
        end
        chk("pre_rst_busy", 64'(sif.busy), 64'h1);
        #2 reset = 1'b0;
        #1;
        chk("arst_ctl", ctl_vec(), 64'h0);
        chk("arst_ct", sif.cipher_out, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        run_op("post_rst", 80'h0, 64'h0, CT_ZERO, 0, 1'b0);
        tick();

        // done_clr on the capture edge, then start together with done_clr.
        run_op("clr_cap", {80{1'b1}}, {64{1'b1}}, CT_ONES, 0, 1'b1);
        sif.cfg_key    = '0;
        sif.cfg_plain  = '0;
        sif.ctrl_start = 1'b1;
        sif.done_clr   = 1'b1;
        tick();
        sif.done_clr   = 1'b0;
        sif.ctrl_start = 1'b0;
        chk("simul_c1", 64'({sif.core_load, sif.busy, sif.done}), 64'h6);
        n = 0;
        while (!sif.done && n < 60) begin
            tick();
            n++;
        end
        chk("simul_wait", 64'(n), 64'd34);
        chk("simul_ct", sif.cipher_out, CT_ZERO);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
